// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg: shared state encoding and line level for the FIFO-fed UART transmitter.
package fifo_uart_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} tx_state_t;
    localparam logic UART_IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running bit-period counter, ticks in the last cycle of each UART bit.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    logic [CW-1:0] cnt_q, cnt_d;
    assign tick_o = cnt_q == CW'(CLKS_PER_BIT - 1);
    always_comb cnt_d = (clr_i || tick_o) ? '0 : cnt_q + CW'(1);
    always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a byte FIFO into 8N1 UART frames on tx.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_pop,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int IW = $clog2(DATA_WIDTH) + 1;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam tx_state_t AFTER_DATA = PARITY;
`else
    localparam tx_state_t AFTER_DATA = STOP;
`endif
    tx_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  tx_q, pop_q, busy_q, done_q, line_d, tick, clr;
    assign clr        = state_q inside {IDLE, FETCH, LOAD};
    assign tx         = tx_q;
    assign fifo_pop   = pop_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr),
        .tick_o (tick)
    );
`ifdef FIFO_UART_TX_PARITY_EN
    logic par_q;
    always_ff @(posedge clk) begin
        if (rst) par_q <= 1'b0;
        else if (state_q == LOAD) par_q <= ^fifo_rdata;
    end
`endif
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        line_d  = UART_IDLE_LEVEL;
        case (state_q)
            IDLE:  state_d = fifo_empty ? IDLE : FETCH;
            FETCH: state_d = LOAD;
            LOAD: begin
                shift_d = fifo_rdata;
                idx_d   = '0;
                state_d = START;
            end
            START: begin
                line_d  = 1'b0;
                state_d = tick ? DATA : START;
            end
            DATA: begin
                line_d = shift_q[0];
                if (tick) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + IW'(1);
                    state_d = (idx_q == IW'(DATA_WIDTH - 1)) ? AFTER_DATA : DATA;
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                line_d  = par_q;
                state_d = tick ? STOP : PARITY;
            end
`endif
            STOP:    state_d = tick ? IDLE : STOP;
            default: state_d = IDLE;
        endcase
    end
    // Outputs lag the state by one cycle, so busy also covers the issue cycle and the trailing stop cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= UART_IDLE_LEVEL;
            pop_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= line_d;
            pop_q   <= state_q == IDLE && !fifo_empty;
            busy_q  <= state_q != IDLE || state_d != IDLE;
            done_q  <= state_q == STOP && tick;
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed frame vectors against a behavioural one-cycle-latency byte FIFO.
module tb_fifo_uart_tx;
    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    typedef struct {
        logic [7:0] d;
        logic [9:0] frame;
        logic       par;
    } vec_t;
    vec_t vecs[11];
    logic clk = 1'b0, rst = 1'b1;
    logic fifo_empty, fifo_pop, tx, busy, frame_done;
    logic [7:0] fifo_rdata = '0;
    logic       push = 1'b0;
    logic [7:0] push_data = '0;
    logic [7:0] mem[8];
    logic [2:0] wp = '0, rp = '0;
    int cnt = 0, cyc = 0, pops = 0, dones = 0, pop_cyc = 0;
    int checks = 0, errors = 0;
    logic [10:0] f;
    int fc, e1, b, d, pe, lows;
    always #5 clk = ~clk;
    assign fifo_empty = (cnt == 0);
    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_pop   (fifo_pop),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (push) begin
            mem[wp] <= push_data;
            wp <= wp + 3'd1;
        end
        if (fifo_pop) begin
            fifo_rdata <= mem[rp];
            rp <= rp + 3'd1;
            pops <= pops + 1;
            pop_cyc <= cyc;
        end
        if (frame_done) dones <= dones + 1;
        cnt <= cnt + (push ? 1 : 0) - (fifo_pop ? 1 : 0);
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask
    task automatic do_push(input logic [7:0] v);
        push = 1'b1;
        push_data = v;
        @(negedge clk);
        push = 1'b0;
    endtask
    task automatic wait_fall(output int fcyc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx !== 1'b0 && n < 200);
        if (tx !== 1'b0) chk("start_bit_timeout", 32'(tx), 32'd0);
        fcyc = cyc;
    endtask
    task automatic get_frame(output logic [10:0] fr, output int fcyc);
        logic [10:0] r = '0;
        logic stable = 1'b1;
        wait_fall(fcyc);
        for (int i = 0; i < NB; i++)
            for (int k = 0; k < CPB; k++) begin
                if (i != 0 || k != 0) @(negedge clk);
                if (k == 0) r[i] = tx;
                else if (tx !== r[i]) stable = 1'b0;
            end
        fr = r;
        chk("bit_hold", 32'(stable), 32'd1);
        chk("frame_done_last_stop", 32'(frame_done), 32'd1);
    endtask
    function automatic logic [10:0] exp_of(input vec_t v);
`ifdef FIFO_UART_TX_PARITY_EN
        return {v.frame[9], v.par, v.frame[8:0]};
`else
        return {1'b0, v.frame};
`endif
    endfunction
    initial begin
        vecs[0]  = '{8'hA5, 10'b1_10100101_0, 1'b0};
        vecs[1]  = '{8'h00, 10'b1_00000000_0, 1'b0};
        vecs[2]  = '{8'hFF, 10'b1_11111111_0, 1'b0};
        vecs[3]  = '{8'h07, 10'b1_00000111_0, 1'b1};
        vecs[4]  = '{8'h03, 10'b1_00000011_0, 1'b0};
        vecs[5]  = '{8'h80, 10'b1_10000000_0, 1'b1};
        vecs[6]  = '{8'h01, 10'b1_00000001_0, 1'b1};
        vecs[7]  = '{8'h02, 10'b1_00000010_0, 1'b1};
        vecs[8]  = '{8'h55, 10'b1_01010101_0, 1'b0};
        vecs[9]  = '{8'h3C, 10'b1_00111100_0, 1'b0};
        vecs[10] = '{8'hC3, 10'b1_11000011_0, 1'b0};
        rst = 1'b1;
        do_push(vecs[0].d);
        repeat (3) begin
            @(negedge clk);
            chk("reset_idle", 32'({tx, fifo_pop, busy, frame_done}), 32'b1000);
        end
        chk("reset_no_pop", pops, 0);
        rst = 1'b0;
        get_frame(f, fc);
        chk("pop_to_start", fc - pop_cyc, 3);
        chk("frame_A5", 32'(f), 32'(exp_of(vecs[0])));
        @(negedge clk);
        chk("idle_after_A5", 32'({busy, fifo_empty, tx}), 32'b011);
        chk("one_pop", pops, 1);
        chk("one_done", dones, 1);
        for (int i = 1; i < 6; i++) begin
            b = pops;
            d = dones;
            do_push(vecs[i].d);
            get_frame(f, fc);
            chk($sformatf("frame_%02h", vecs[i].d), 32'(f), 32'(exp_of(vecs[i])));
            @(negedge clk);
            chk($sformatf("pops_%02h", vecs[i].d), pops, b + 1);
            chk($sformatf("dones_%02h", vecs[i].d), dones, d + 1);
        end
        b = pops;
        do_push(vecs[6].d);
        do_push(vecs[7].d);
        do_push(vecs[4].d);
        get_frame(f, fc);
        chk("b2b_frame_01", 32'(f), 32'(exp_of(vecs[6])));
        e1 = cyc;
        get_frame(f, fc);
        chk("b2b_frame_02", 32'(f), 32'(exp_of(vecs[7])));
        chk("b2b_gap_1", fc - e1 - 1, 3);
        e1 = cyc;
        get_frame(f, fc);
        chk("b2b_frame_03", 32'(f), 32'(exp_of(vecs[4])));
        chk("b2b_gap_2", fc - e1 - 1, 3);
        @(negedge clk);
        chk("b2b_pops", pops, b + 3);
        b = pops;
        fork
            begin
                do_push(vecs[8].d);
                get_frame(f, fc);
                pe = pops;
            end
            begin
                repeat (12) @(negedge clk);
                do_push(vecs[2].d);
            end
        join
        chk("mid_frame_no_pop", pe, b + 1);
        chk("mid_frame_55", 32'(f), 32'(exp_of(vecs[8])));
        get_frame(f, fc);
        chk("mid_frame_FF", 32'(f), 32'(exp_of(vecs[2])));
        @(negedge clk);
        chk("mid_frame_pops", pops, b + 2);
        do_push(vecs[9].d);
        wait_fall(fc);
        repeat (21) @(negedge clk);
        chk("bit4_of_3C", 32'({tx, busy}), 32'b11);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_abort", 32'({tx, busy, fifo_pop, frame_done}), 32'b1000);
        rst = 1'b0;
        b = pops;
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        chk("quiet_after_rst", lows, 0);
        chk("no_pop_after_rst", pops, b);
        do_push(vecs[10].d);
        get_frame(f, fc);
        chk("clean_after_rst_C3", 32'(f), 32'(exp_of(vecs[10])));
        @(negedge clk);
        chk("pops_after_rst", pops, b + 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want $finish");
        $fatal(1, "watchdog");
    end
endmodule
